nat_join2_d_sync: RTL and testbench

NAT_JOIN2_D_SYNC -- requirements
Module: nat_join2_d_sync

---
 rtl/nat_join2_d_sync.sv | 156 +++++++++++++++
 tb/tb_nat_join2_d_sync.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nat_join2_d_sync.sv
`default_nettype none
// ============================================================================
// Module      : nat_join2_d_sync
// Description : Two-input join with delayed free return. Collects one drive
//               event (plus data word) from each of two upstream producers,
//               issues a single joined drive downstream carrying
//               {data1, data0}, then returns a free to both producers
//               FREE_DELAY cycles after the downstream free is accepted.
//               Protocol violations are ignored and raise a sticky error.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               i_drive0/1, i_data0/1 - upstream drive pulses and data
//               o_driveNext, o_data   - joined drive pulse and {d1, d0}
//               i_freeNext            - downstream free pulse
//               o_free0/1             - free pulses back to upstream
//               o_err                 - sticky protocol-error flag
// Revision    : 1.0 - initial release
// ============================================================================
module nat_join2_d_sync #(
  parameter int DATA_WIDTH = 10,
  parameter int FREE_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_drive0,
  input  logic                    i_drive1,
  input  logic [DATA_WIDTH-1:0]   i_data0,
  input  logic [DATA_WIDTH-1:0]   i_data1,
  output logic                    o_driveNext,
  output logic [2*DATA_WIDTH-1:0] o_data,
  input  logic                    i_freeNext,
  output logic                    o_free0,
  output logic                    o_free1,
  output logic                    o_err
);

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    FIRE      = 3'd1,
    WAIT_FREE = 3'd2,
    DELAY     = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  // Counter reload value; guarded so FREE_DELAY=0 does not wrap.
  localparam int         C_LOAD_I   = (FREE_DELAY > 0) ? (FREE_DELAY - 1) : 0;
  localparam logic [3:0] C_CNT_LOAD = C_LOAD_I[3:0];

  state_t                  r_state, w_state_nxt;
  logic                    r_arr0, r_arr1, w_arr0_nxt, w_arr1_nxt;
  logic [DATA_WIDTH-1:0]   r_d0, r_d1, w_d0_nxt, w_d1_nxt;
  logic [3:0]              r_cnt, w_cnt_nxt;
  logic [2*DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                    r_err;

  logic w_in_collect;
  logic w_acc0, w_acc1;
  logic w_free_ok, w_acc_free;
  logic w_err_evt;

  always_comb begin
    w_state_nxt = r_state;
    w_arr0_nxt  = r_arr0;
    w_arr1_nxt  = r_arr1;
    w_d0_nxt    = r_d0;
    w_d1_nxt    = r_d1;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;

    w_in_collect = (r_state == COLLECT);
    // A drive is only taken in COLLECT into an empty slot; anything else is
    // dropped and flagged without disturbing the held word.
    w_acc0       = i_drive0 && w_in_collect && !r_arr0;
    w_acc1       = i_drive1 && w_in_collect && !r_arr1;
    w_free_ok    = (r_state == FIRE) || (r_state == WAIT_FREE);
    w_acc_free   = i_freeNext && w_free_ok;
    w_err_evt    = (i_drive0 && !w_acc0) || (i_drive1 && !w_acc1) ||
                   (i_freeNext && !w_free_ok);

    if (w_acc0) begin
      w_arr0_nxt = 1'b1;
      w_d0_nxt   = i_data0;
    end
    if (w_acc1) begin
      w_arr1_nxt = 1'b1;
      w_d1_nxt   = i_data1;
    end

    case (r_state)
      COLLECT: begin
        // Output word is captured on the same edge that completes the pair,
        // so it is already valid in the FIRE cycle and held afterwards.
        if (w_arr0_nxt && w_arr1_nxt) begin
          w_state_nxt = FIRE;
          w_data_nxt  = {w_d1_nxt, w_d0_nxt};
        end
      end
      FIRE, WAIT_FREE: begin
        if (w_acc_free) begin
          if (FREE_DELAY == 0) begin
            w_state_nxt = RELEASE;
          end else begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = C_CNT_LOAD;
          end
        end else begin
          w_state_nxt = WAIT_FREE;
        end
      end
      DELAY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RELEASE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RELEASE: begin
        w_arr0_nxt  = 1'b0;
        w_arr1_nxt  = 1'b0;
        w_state_nxt = COLLECT;
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_arr0  <= 1'b0;
      r_arr1  <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_cnt   <= 4'd0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_arr0  <= w_arr0_nxt;
      r_arr1  <= w_arr1_nxt;
      r_d0    <= w_d0_nxt;
      r_d1    <= w_d1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_err   <= r_err | w_err_evt;
    end
  end

  assign o_driveNext = (r_state == FIRE);
  assign o_free0     = (r_state == RELEASE);
  assign o_free1     = (r_state == RELEASE);
  assign o_data      = r_data;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nat_join2_d_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_nat_join2_d_sync
// Description : Bench for nat_join2_d_sync. Two instances share stimulus:
//               inst A (FREE_DELAY=2) and inst B (FREE_DELAY=0). A directed
//               vector table exercises the documented sequences on inst A;
//               a randomized phase compares both against an event-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nat_join2_d_sync;

  localparam int DW = 10;

  logic          clk;
  logic          s_rst, s_d0, s_d1, s_fr;
  logic [DW-1:0] s_x0, s_x1;

  logic          a_dn, a_f0, a_f1, a_err;
  logic [2*DW-1:0] a_data;
  logic          b_dn, b_f0, b_f1, b_err;
  logic [2*DW-1:0] b_data;

  nat_join2_d_sync #(.DATA_WIDTH(DW), .FREE_DELAY(2)) dut (
    .clk(clk), .rst(s_rst),
    .i_drive0(s_d0), .i_drive1(s_d1), .i_data0(s_x0), .i_data1(s_x1),
    .o_driveNext(a_dn), .o_data(a_data), .i_freeNext(s_fr),
    .o_free0(a_f0), .o_free1(a_f1), .o_err(a_err)
  );

  nat_join2_d_sync #(.DATA_WIDTH(DW), .FREE_DELAY(0)) dut0 (
    .clk(clk), .rst(s_rst),
    .i_drive0(s_d0), .i_drive1(s_d1), .i_data0(s_x0), .i_data1(s_x1),
    .o_driveNext(b_dn), .o_data(b_data), .i_freeNext(s_fr),
    .o_free0(b_f0), .o_free1(b_f1), .o_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // ---------------- reference model (event-time based) ----------------
  // A transaction is "busy" from the moment both words are held until the
  // release cycle; fire_at / rel_at are absolute cycle numbers.
  bit            m_have0[2], m_have1[2], m_busy[2], m_err[2];
  logic [DW-1:0] m_d0[2], m_d1[2];
  logic [2*DW-1:0] m_data[2];
  int            m_fire_at[2], m_rel_at[2];

  function automatic int dly(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_reset(input int i);
    m_have0[i] = 0; m_have1[i] = 0; m_busy[i] = 0; m_err[i] = 0;
    m_d0[i] = '0; m_d1[i] = '0; m_data[i] = '0;
    m_fire_at[i] = -1; m_rel_at[i] = -1;
  endtask

  task automatic model_step(input int i);
    bit coll, a0, a1, win, e, rel;
    if (s_rst) begin
      model_reset(i);
    end else begin
      coll = !m_busy[i];
      a0   = s_d0 && coll && !m_have0[i];
      a1   = s_d1 && coll && !m_have1[i];
      win  = m_busy[i] && (cyc >= m_fire_at[i]) && (m_rel_at[i] < 0);
      e    = (s_d0 && !a0) || (s_d1 && !a1) || (s_fr && !win);
      rel  = m_busy[i] && (m_rel_at[i] == cyc);
      if (a0) begin m_have0[i] = 1; m_d0[i] = s_x0; end
      if (a1) begin m_have1[i] = 1; m_d1[i] = s_x1; end
      if (coll && m_have0[i] && m_have1[i]) begin
        m_busy[i]    = 1;
        m_fire_at[i] = cyc + 1;
        m_data[i]    = {m_d1[i], m_d0[i]};
      end
      if (s_fr && win) m_rel_at[i] = cyc + 1 + dly(i);
      if (rel) begin
        m_busy[i] = 0; m_have0[i] = 0; m_have1[i] = 0;
        m_fire_at[i] = -1; m_rel_at[i] = -1;
      end
      if (e) m_err[i] = 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
  endtask

  task automatic chk_model(input int i, input logic dn, input logic f0, input logic f1,
                           input logic [2*DW-1:0] dat, input logic er);
    string p;
    p = (i == 0) ? "A" : "B";
    chk({p, ".driveNext"}, 32'(dn),  32'(m_fire_at[i] == cyc));
    chk({p, ".free0"},     32'(f0),  32'(m_rel_at[i] == cyc));
    chk({p, ".free1"},     32'(f1),  32'(m_rel_at[i] == cyc));
    chk({p, ".data"},      32'(dat), 32'(m_data[i]));
    chk({p, ".err"},       32'(er),  32'(m_err[i]));
  endtask

  // Apply current stimulus across one rising edge; return at the next
  // falling edge, where outputs are sampled.
  task automatic do_cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic v0, input logic [DW-1:0] x0,
                        input logic v1, input logic [DW-1:0] x1, input logic fr);
    s_rst = r; s_d0 = v0; s_x0 = x0; s_d1 = v1; s_x1 = x1; s_fr = fr;
  endtask

  // ---------------- directed vector table (inst A, FREE_DELAY=2) ----------
  typedef struct packed {
    logic          rst;
    logic          v0;
    logic [DW-1:0] x0;
    logic          v1;
    logic [DW-1:0] x1;
    logic          fr;
    logic          e_dn;
    logic          e_fr;
    logic [2*DW-1:0] e_data;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v0, input logic [DW-1:0] x0,
                     input logic v1, input logic [DW-1:0] x1, input logic fr,
                     input logic edn, input logic efr, input logic [2*DW-1:0] ed,
                     input logic eer);
    vec_t v;
    v.rst = r; v.v0 = v0; v.x0 = x0; v.v1 = v1; v.x1 = x1; v.fr = fr;
    v.e_dn = edn; v.e_fr = efr; v.e_data = ed; v.e_err = eer;
    tbl.push_back(v);
  endtask

  initial begin
    // Row: inputs applied this cycle | outputs expected this cycle.
    // Basic join: drive0 at 0, drive1 at 3, fire at 4, free at 6 -> release 9.
    add(0,1,10'h155,0,10'h000,0, 0,0,20'h00000,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h00000,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h00000,0);
    add(0,0,10'h000,1,10'h0AA,0, 0,0,20'h00000,0);
    add(0,0,10'h000,0,10'h000,0, 1,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,1, 0,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,0, 0,1,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h2A955,0);
    // Simultaneous drives, free taken in FIRE, new drives right after release.
    add(0,1,10'h001,1,10'h3FF,0, 0,0,20'h2A955,0);
    add(0,0,10'h000,0,10'h000,1, 1,0,20'hFFC01,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'hFFC01,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'hFFC01,0);
    add(0,0,10'h000,0,10'h000,0, 0,1,20'hFFC01,0);
    add(0,1,10'h123,0,10'h000,0, 0,0,20'hFFC01,0);
    // Repeated drive0: error, first word kept.
    add(0,1,10'h0FF,0,10'h000,0, 0,0,20'hFFC01,0);
    add(0,0,10'h000,1,10'h200,0, 0,0,20'hFFC01,1);
    add(0,0,10'h000,0,10'h000,0, 1,0,20'h80123,1);
    add(0,0,10'h000,0,10'h000,1, 0,0,20'h80123,1);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h80123,1);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h80123,1);
    add(0,0,10'h000,0,10'h000,0, 0,1,20'h80123,1);
    // Reset, then unsolicited free in COLLECT.
    add(1,0,10'h000,0,10'h000,0, 0,0,20'h80123,1);
    add(0,0,10'h000,0,10'h000,1, 0,0,20'h00000,0);
    add(0,1,10'h055,1,10'h0AA,0, 0,0,20'h00000,1);
    add(0,0,10'h000,0,10'h000,0, 1,0,20'h2A855,1);
    // Reset while waiting for free: no free pulse afterwards.
    add(1,0,10'h000,0,10'h000,0, 0,0,20'h2A855,1);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h00000,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h00000,0);
    add(0,1,10'h011,1,10'h022,0, 0,0,20'h00000,0);
    add(0,0,10'h000,0,10'h000,0, 1,0,20'h08811,0);
    add(0,0,10'h000,0,10'h000,1, 0,0,20'h08811,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h08811,0);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h08811,0);
    // Drive during RELEASE is an error and is dropped.
    add(0,1,10'h3C3,0,10'h000,0, 0,1,20'h08811,0);
    add(0,0,10'h000,1,10'h001,0, 0,0,20'h08811,1);
    add(0,0,10'h000,0,10'h000,0, 0,0,20'h08811,1);
    add(0,1,10'h002,0,10'h000,0, 0,0,20'h08811,1);
    add(0,0,10'h000,0,10'h000,0, 1,0,20'h00402,1);

    set_in(1, 0, '0, 0, '0, 0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    do_cycle();
    set_in(1, 0, '0, 0, '0, 0);
    do_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      chk("tbl.driveNext", 32'(a_dn),   32'(tbl[i].e_dn));
      chk("tbl.free0",     32'(a_f0),   32'(tbl[i].e_fr));
      chk("tbl.free1",     32'(a_f1),   32'(tbl[i].e_fr));
      chk("tbl.data",      32'(a_data), 32'(tbl[i].e_data));
      chk("tbl.err",       32'(a_err),  32'(tbl[i].e_err));
      chk_model(1, b_dn, b_f0, b_f1, b_data, b_err);
      set_in(tbl[i].rst, tbl[i].v0, tbl[i].x0, tbl[i].v1, tbl[i].x1, tbl[i].fr);
      do_cycle();
    end

    // Randomized phase: mostly legal traffic, occasional protocol errors
    // and resets, checked on both instances against the model.
    set_in(1, 0, '0, 0, '0, 0);
    do_cycle();
    for (int n = 0; n < 3000; n++) begin
      chk_model(0, a_dn, a_f0, a_f1, a_data, a_err);
      chk_model(1, b_dn, b_f0, b_f1, b_data, b_err);
      set_in(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 3) == 0), DW'($urandom),
             ($urandom_range(0, 3) == 0), DW'($urandom),
             ($urandom_range(0, 2) == 0));
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
